// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters,
// Execute-stage training, mispredict detection and a saturating mispredict counter.
module branch_predictor #(
  parameter int PC_WIDTH    = 16,
  parameter int ENTRIES     = 16,
  parameter int PREDICT_EN  = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [PC_WIDTH-1:0]    pcF_i,
  output logic                   predict_taken_o,
  output logic [PC_WIDTH-1:0]    predict_target_o,
  input  logic                   update_en_i,
  input  logic [PC_WIDTH-1:0]    update_pc_i,
  input  logic                   update_taken_i,
  input  logic [PC_WIDTH-1:0]    update_target_i,
  input  logic                   update_is_jump_i,
  input  logic                   update_pred_taken_i,
  input  logic [PC_WIDTH-1:0]    update_pred_target_i,
  output logic                   mispredict_o,
  output logic [PC_WIDTH-1:0]    redirect_pc_o,
  output logic [COUNT_WIDTH-1:0] mispred_count_o
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_WIDTH - IDX_W - 2;
  localparam logic PRED_ON = (PREDICT_EN != 0);
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(3'd4);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  logic              valid_r   [ENTRIES];
  logic [TAG_W-1:0]  tag_r     [ENTRIES];
  logic [PC_WIDTH-1:0] target_r[ENTRIES];
  logic [1:0]        ctr_r     [ENTRIES];
  logic              is_jump_r [ENTRIES];
  logic [COUNT_WIDTH-1:0] count_r;

  logic [IDX_W-1:0]    look_idx_s;
  logic [TAG_W-1:0]    look_tag_s;
  logic                look_hit_s;
  logic                pred_taken_s;
  logic [PC_WIDTH-1:0] pred_target_s;

  logic [IDX_W-1:0]    upd_idx_s;
  logic [TAG_W-1:0]    upd_tag_s;
  logic                upd_hit_s;
  logic                upd_write_s;
  logic [1:0]          upd_ctr_s;
  logic [PC_WIDTH-1:0] upd_target_s;
  logic                upd_jump_s;

  logic                mispredict_s;
  logic [PC_WIDTH-1:0] redirect_s;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    if (c == 2'b11) begin
      ctr_inc = 2'b11;
    end else begin
      ctr_inc = c + 2'b01;
    end
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    if (c == 2'b00) begin
      ctr_dec = 2'b00;
    end else begin
      ctr_dec = c - 2'b01;
    end
  endfunction

  // Fetch lookup: reads pre-update table state, no bypass from the write port
  always_comb begin
    look_idx_s = pcF_i[IDX_W+1:2];
    look_tag_s = pcF_i[PC_WIDTH-1:IDX_W+2];
    look_hit_s = valid_r[look_idx_s] && (tag_r[look_idx_s] == look_tag_s);
    if (PRED_ON && look_hit_s && (is_jump_r[look_idx_s] || ctr_r[look_idx_s][1])) begin
      pred_taken_s  = 1'b1;
      pred_target_s = target_r[look_idx_s];
    end else begin
      pred_taken_s  = 1'b0;
      pred_target_s = pcF_i + PC_STEP;
    end
  end

  // Next value of the entry addressed by the resolving instruction
  always_comb begin
    upd_idx_s    = update_pc_i[IDX_W+1:2];
    upd_tag_s    = update_pc_i[PC_WIDTH-1:IDX_W+2];
    upd_hit_s    = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
    upd_write_s  = PRED_ON && update_en_i && (upd_hit_s || update_taken_i);
    upd_ctr_s    = ctr_r[upd_idx_s];
    upd_target_s = target_r[upd_idx_s];
    upd_jump_s   = is_jump_r[upd_idx_s];
    if (upd_hit_s && update_taken_i) begin
      upd_ctr_s    = ctr_inc(ctr_r[upd_idx_s]);
      upd_target_s = update_target_i;
      upd_jump_s   = update_is_jump_i;
    end else if (upd_hit_s) begin
      upd_ctr_s    = ctr_dec(ctr_r[upd_idx_s]);
    end else begin
      // miss allocates weakly taken; a miss that is not taken is never written
      upd_ctr_s    = 2'b10;
      upd_target_s = update_target_i;
      upd_jump_s   = update_is_jump_i;
    end
    if (upd_jump_s) begin
      upd_ctr_s = 2'b11;
    end else begin
      upd_ctr_s = upd_ctr_s;
    end
  end

  // Mispredict detection and the correct next PC for the redirect
  always_comb begin
    mispredict_s = update_en_i &&
                   ((update_taken_i != update_pred_taken_i) ||
                    (update_taken_i && (update_target_i != update_pred_target_i)));
    if (update_taken_i) begin
      redirect_s = update_target_i;
    end else begin
      redirect_s = update_pc_i + PC_STEP;
    end
  end

  // Table and statistics state; reset wins over a same-edge update
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]   <= 1'b0;
        tag_r[i]     <= '0;
        target_r[i]  <= '0;
        ctr_r[i]     <= 2'b01;
        is_jump_r[i] <= 1'b0;
      end
      count_r <= '0;
    end else begin
      if (upd_write_s) begin
        valid_r[upd_idx_s]   <= 1'b1;
        tag_r[upd_idx_s]     <= upd_tag_s;
        target_r[upd_idx_s]  <= upd_target_s;
        ctr_r[upd_idx_s]     <= upd_ctr_s;
        is_jump_r[upd_idx_s] <= upd_jump_s;
      end
      if (mispredict_s && (count_r != COUNT_MAX)) begin
        count_r <= count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign predict_taken_o  = pred_taken_s;
  assign predict_target_o = pred_target_s;
  assign mispredict_o     = mispredict_s;
  assign redirect_pc_o    = redirect_s;
  assign mispred_count_o  = count_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: a dynamic predictor and a static (PREDICT_EN=0, 4-bit counter)
// instance share stimulus; a reference model pushes expectations, a monitor checks.
module tb_branch_predictor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic [15:0] pcf, upc, utgt, uptgt;
  logic        uen, utaken, ujump, uptaken;

  logic        pt_a, mp_a, pt_b, mp_b;
  logic [15:0] ptgt_a, rd_a, cnt_a, ptgt_b, rd_b;
  logic [3:0]  cnt_b;

  branch_predictor #(.PC_WIDTH(16), .ENTRIES(16), .PREDICT_EN(1), .COUNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .pcF_i(pcf),
    .predict_taken_o(pt_a), .predict_target_o(ptgt_a),
    .update_en_i(uen), .update_pc_i(upc), .update_taken_i(utaken),
    .update_target_i(utgt), .update_is_jump_i(ujump),
    .update_pred_taken_i(uptaken), .update_pred_target_i(uptgt),
    .mispredict_o(mp_a), .redirect_pc_o(rd_a), .mispred_count_o(cnt_a));

  branch_predictor #(.PC_WIDTH(16), .ENTRIES(16), .PREDICT_EN(0), .COUNT_WIDTH(4)) dut_static (
    .clk_i(clk), .rst_i(rst_i), .pcF_i(pcf),
    .predict_taken_o(pt_b), .predict_target_o(ptgt_b),
    .update_en_i(uen), .update_pc_i(upc), .update_taken_i(utaken),
    .update_target_i(utgt), .update_is_jump_i(ujump),
    .update_pred_taken_i(uptaken), .update_pred_target_i(uptgt),
    .mispredict_o(mp_b), .redirect_pc_o(rd_b), .mispred_count_o(cnt_b));

  typedef struct {
    int pt; int ptgt; int mp; int rd; int cnt; int ptgt_b; int cnt_b;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  // reference model: one record per direct-mapped slot
  bit m_valid[16];
  int m_tag[16];
  int m_tgt[16];
  int m_ctr[16];
  bit m_jump[16];
  int m_cnt, m_cnt_b;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_ctr[i] = 1; m_jump[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 0;
    end
    m_cnt = 0; m_cnt_b = 0;
  endtask

  task automatic model_train(input int pc, input bit tk, input int tg, input bit jp);
    int idx, tag;
    bit hit;
    idx = (pc / 4) % 16;
    tag = pc / 64;
    hit = m_valid[idx] && (m_tag[idx] == tag);
    if (hit) begin
      if (tk) begin
        m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
        m_tgt[idx] = tg; m_jump[idx] = jp;
      end else begin
        m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
      end
      if (m_jump[idx]) m_ctr[idx] = 3;
    end else if (tk) begin
      m_valid[idx] = 1'b1; m_tag[idx] = tag; m_tgt[idx] = tg; m_jump[idx] = jp;
      m_ctr[idx] = jp ? 3 : 2;
    end
  endtask

  task automatic step(input bit rst, input int pc_f, input bit en, input int pc_u,
                      input bit tk, input int tg, input bit jp, input bit ptk, input int ptg);
    exp_t e;
    int idx, tag;
    bit hit;
    @(posedge clk);
    #1;
    rst_i = rst; pcf = pc_f[15:0]; uen = en; upc = pc_u[15:0]; utaken = tk;
    utgt = tg[15:0]; ujump = jp; uptaken = ptk; uptgt = ptg[15:0];
    idx = (pc_f / 4) % 16;
    tag = pc_f / 64;
    hit = m_valid[idx] && (m_tag[idx] == tag);
    e.pt     = (hit && (m_jump[idx] || m_ctr[idx] >= 2)) ? 1 : 0;
    e.ptgt   = (e.pt == 1) ? m_tgt[idx] : (pc_f + 4) % 65536;
    e.mp     = (en && ((tk != ptk) || (tk && tg != ptg))) ? 1 : 0;
    e.rd     = tk ? tg : (pc_u + 4) % 65536;
    e.cnt    = m_cnt;
    e.ptgt_b = (pc_f + 4) % 65536;
    e.cnt_b  = m_cnt_b;
    q.push_back(e);
    if (!rst) begin
      model_reset();
    end else begin
      if (e.mp == 1) begin
        m_cnt   = (m_cnt == 65535) ? 65535 : m_cnt + 1;
        m_cnt_b = (m_cnt_b == 15) ? 15 : m_cnt_b + 1;
      end
      if (en) model_train(pc_u, tk, tg, jp);
    end
  endtask

  task automatic look(input int pc);
    step(1'b1, pc, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // monitor: outputs are combinational, so every cycle is a response
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("predict_taken",   {31'd0, pt_a},   e.pt);
      chk("predict_target",  {16'd0, ptgt_a}, e.ptgt);
      chk("mispredict",      {31'd0, mp_a},   e.mp);
      chk("redirect_pc",     {16'd0, rd_a},   e.rd);
      chk("mispred_count",   {16'd0, cnt_a},  e.cnt);
      chk("static_taken",    {31'd0, pt_b},   32'd0);
      chk("static_target",   {16'd0, ptgt_b}, e.ptgt_b);
      chk("static_mispred",  {31'd0, mp_b},   e.mp);
      chk("static_redirect", {16'd0, rd_b},   e.rd);
      chk("static_count",    {28'd0, cnt_b},  e.cnt_b);
    end
  end

  function automatic int rand_pc();
    int tags[4];
    tags[0] = 0; tags[1] = 1; tags[2] = 2; tags[3] = 1023;
    return tags[$urandom_range(0, 3)] * 64 + $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
  endfunction

  initial begin
    rst_i = 1'b0; pcf = 16'h0; uen = 1'b0; upc = 16'h0; utaken = 1'b0;
    utgt = 16'h0; ujump = 1'b0; uptaken = 1'b0; uptgt = 16'h0;
    repeat (2) @(posedge clk);
    model_reset();

    look('h0040);
    // first training update, lookup in the same cycle sees the old state
    step(1, 'h0040, 1, 'h0040, 1, 'h0010, 0, 0, 0);
    step(1, 'h0040, 1, 'h0040, 0, 0, 0, 1, 'h0010);
    step(1, 'h0040, 1, 'h0040, 0, 0, 0, 0, 0);
    look('h0040);

    // aliasing: 0x0080 shares index 0 with 0x0040
    step(1, 'h0040, 1, 'h0040, 1, 'h0010, 0, 0, 0);
    step(1, 'h0040, 1, 'h0040, 1, 'h0010, 0, 0, 0);
    look('h0040);
    look('h0080);
    step(1, 'h0080, 1, 'h0080, 1, 'h0200, 0, 0, 0);
    look('h0040);
    look('h0080);
    for (int i = 0; i < 4; i++) step(1, 'h0080, 1, 'h0080, 1, 'h0200, 0, 1, 'h0200);
    step(1, 'h0080, 1, 'h0080, 0, 0, 0, 1, 'h0200);
    look('h0080);

    // mispredict flavours
    step(1, 'h0020, 1, 'h0020, 1, 'h0100, 0, 0, 0);
    step(1, 'h0020, 1, 'h0020, 0, 0, 0, 1, 'h0100);
    step(1, 'h0020, 1, 'h0020, 1, 'h0104, 0, 1, 'h0100);
    look('h0020);

    // jump at the top of the address space and PC wrap
    step(1, 'hFFFC, 1, 'hFFFC, 1, 'h0008, 1, 0, 0);
    look('hFFFC);
    look('hFFF8);
    step(1, 'hFFFC, 1, 'hFFFC, 0, 0, 0, 1, 'h0008);
    look('hFFFC);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      int pu, tg, ptg;
      bit jp, tk, ptk;
      pu  = rand_pc();
      tg  = $urandom_range(0, 65535);
      jp  = ($urandom_range(0, 5) == 0);
      tk  = jp ? 1'b1 : 1'($urandom_range(0, 1));
      ptk = 1'($urandom_range(0, 1));
      ptg = ($urandom_range(0, 1) == 1) ? tg : $urandom_range(0, 65535);
      step(($urandom_range(0, 60) != 0), rand_pc(), 1'($urandom_range(0, 1)),
           pu, tk, tg, jp, ptk, ptg);
    end

    // reset on the same edge as a taken update discards it
    step(1, 'h0040, 1, 'h0040, 1, 'h0010, 0, 0, 0);
    step(1, 'h0040, 1, 'h0040, 1, 'h0010, 0, 1, 'h0010);
    step(0, 'h0080, 1, 'h0080, 1, 'h0300, 0, 0, 0);
    look('h0040);
    look('h0080);
    look('hFFFC);

    // counter saturation: 2^4+3 mispredicts saturate the small counter
    for (int i = 0; i < 19; i++) step(1, 'h0100, 1, 'h0140, 1, 'h0500 + i * 4, 0, 0, 0);
    look('h0140);
    look('h0140);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch target buffer (BTB) with 2-bit saturating direction counters for the pipelined core.
- Replaces the always-not-taken fetch policy, which flushes on every taken branch or jump.
- Looked up combinationally in Fetch with pcF; trained in Execute when a branch or jump resolves.
- Also detects mispredicts and supplies the redirect PC that the hazard unit uses to flush D/E.

Parameters:
- PC_WIDTH, 16, width of all PC/target values.
- ENTRIES, 16, number of BTB entries; must be a power of 2, minimum 2.
- PREDICT_EN, 1, 1 = dynamic prediction; 0 = static not-taken (table never written).
- COUNT_WIDTH, 16, width of the mispredict statistics counter.
- Derived, not overridable: IDX_W = log2(ENTRIES); index = pc[IDX_W+1:2]; tag = pc[PC_WIDTH-1:IDX_W+2].

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  synchronous, active-low reset.
- pcF_i  in  PC_WIDTH  fetch-stage PC to look up.
- predict_taken_o  out  1  Fetch should take predict_target_o.
- predict_target_o  out  PC_WIDTH  predicted next PC.
- update_en_i  in  1  Execute-stage branch/jump resolved this cycle.
- update_pc_i  in  PC_WIDTH  PC of the resolving instruction (pcE).
- update_taken_i  in  1  actual outcome (jumps always 1).
- update_target_i  in  PC_WIDTH  actual target (pc_target).
- update_is_jump_i  in  1  instruction is JAL/JALR.
- update_pred_taken_i  in  1  prediction carried down the pipeline with the instruction.
- update_pred_target_i  in  PC_WIDTH  predicted target carried down the pipeline.
- mispredict_o  out  1  flush D/E and redirect fetch.
- redirect_pc_o  out  PC_WIDTH  correct next PC on mispredict.
- mispred_count_o  out  COUNT_WIDTH  saturating mispredict counter.

Behaviour:
- Per-entry state: valid, tag, target[PC_WIDTH], ctr[1:0], is_jump.
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx] == tag(pcF_i); pcF_i[1:0] is ignored.
  - predict_taken_o = PREDICT_EN && hit && (is_jump[idx] || ctr[idx][1]).
  - predict_target_o = predict_taken_o ? target[idx] : pcF_i + 4, computed modulo 2^PC_WIDTH (0xFFFC + 4 = 0x0000).
- Update (registered, applied on the edge where update_en_i=1 and PREDICT_EN=1):
  - Hit, taken: ctr saturating increment (max 11); target and is_jump overwritten.
  - Hit, not taken: ctr saturating decrement (min 00); target unchanged.
  - Miss, taken: allocate the entry, overwriting any aliased entry: valid=1, tag, target, is_jump, ctr=10 (weakly taken).
  - Miss, not taken: no state change.
  - Jump entries: ctr forced to 11 on every write.
- Same-cycle lookup and update of the same index: lookup returns pre-update state; no bypass. The new state is visible on the next cycle.
- Mispredict detection (combinational):
  - mispredict_o = update_en_i && ((update_taken_i != update_pred_taken_i) || (update_taken_i && update_target_i != update_pred_target_i)).
  - redirect_pc_o = update_taken_i ? update_target_i : update_pc_i + 4 (wraps).
  - Both outputs are valid when PREDICT_EN=0.
- mispred_count_o increments by 1 on each cycle with mispredict_o=1; it holds at all-ones and does not wrap.
- Reset (rst_i=0 at clock edge) has priority over update. After reset: all valid=0, all ctr=01, mispred_count_o=0. Consequently predict_taken_o=0 for any PC after reset, and mispredict_o/redirect_pc_o follow their inputs only.
- Reset asserted mid-training discards the update on that edge.

Test Plan:
- ENTRIES=16, so index = pc[5:2] and tag = pc[15:6].
- Reset, lookup pcF_i=0x0040 -> predict_taken_o=0, predict_target_o=0x0044, mispred_count_o=0.
- Update pc=0x0040, taken, target=0x0010 -> next cycle lookup 0x0040 gives taken=1, target=0x0010. Then two not-taken updates -> ctr=00; lookup gives taken=0, target=0x0044. Confirm a same-cycle lookup during the first update still sees pre-update state.
- Alias: with 0x0040 trained taken, lookup 0x0080 (same index 0, different tag) -> taken=0. Taken update 0x0080 -> 0x0200 evicts the entry; 0x0040 now misses and 0x0080 predicts 0x0200. Saturation: 4 taken updates, then 1 not-taken -> still predicts taken (ctr=10).
- Mispredict: update_en=1, pc=0x0020, pred_taken=0, taken=1, target=0x0100 -> mispredict_o=1, redirect=0x0100, count 0 to 1. Then pred_taken=1, pred_target=0x0100, taken=0 -> mispredict_o=1, redirect=0x0024. Then pred_taken=1, pred_target=0x0100, taken=1, target=0x0104 -> mispredict_o=1.
- Jump and wrap: jump at 0xFFFC, target 0x0008, is_jump=1 -> later lookup predicts 0x0008. Lookup of untrained 0xFFF8 gives target 0xFFFC. With PREDICT_EN=0, lookups of trained PCs give 0 while counting still works.
- Reset mid-operation: assert rst_i=0 on the same edge as a taken update -> afterwards all lookups miss and mispred_count_o=0. Force 2^COUNT_WIDTH+3 mispredicts -> counter holds at all-ones.
